// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 memory access path.
package lc3_mem_pkg;

  localparam logic [15:0] MMIO_SWITCH_HEX_ADDR = 16'hFFFF;
  localparam int          SRAM_ADDR_W          = 20;

  typedef enum logic [2:0] {
    IDLE,
    R_ACC,
    W_ACC,
    W_REC,
    HOLD
  } mem_state_t;

  function automatic logic is_mmio(input logic [15:0] addr);
    return addr == MMIO_SWITCH_HEX_ADDR;
  endfunction

endpackage

// File: rtl/sram_dq_tristate.sv
// Bidirectional 16-bit buffer between the controller and the SRAM data pins.
module sram_dq_tristate (
  inout  wire  [15:0] dq,
  input  logic        drive_en,
  input  logic [15:0] drive_data,
  output logic [15:0] sample_data
);

  assign dq          = drive_en ? drive_data : 16'hzzzz;
  assign sample_data = dq;

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences async-SRAM cycles from the control unit's Mem_OE/Mem_WE levels and
// decodes the switch/hex MMIO word at 0xFFFF.
module mem_access_ctrl
  import lc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic [15:0]            MAR,
  input  logic [15:0]            MDR,
  input  logic [15:0]            Switches,
  output logic [15:0]            Mem_Data,
  output logic                   Mem_Ready,
  output logic [15:0]            Hex_Out,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]            SRAM_DQ,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output mem_state_t             state_dbg
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  mem_state_t  state;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        mmio_q;
  logic        dq_en;
  logic [15:0] dq_rd;

  sram_dq_tristate u_dq (
    .dq          (SRAM_DQ),
    .drive_en    (dq_en),
    .drive_data  (wdata_q),
    .sample_data (dq_rd)
  );

  assign SRAM_ADDR = SRAM_ADDR_W'(addr_q);
  assign state_dbg = state;

  // Handshake: Mem_OE/Mem_WE are level requests sampled only in IDLE; Mem_Ready
  // pulses for one cycle when read data is valid or the write has completed, and
  // a new request is accepted only after both strobes have been seen low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mmio_q    <= 1'b0;
      dq_en     <= 1'b0;
      Mem_Data  <= '0;
      Mem_Ready <= 1'b0;
      Hex_Out   <= '0;
      SRAM_CE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_WE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
    end else begin
      Mem_Ready <= 1'b0;
      case (state)
        IDLE: begin
          // Write wins a tie so a simultaneous OE+WE never reads.
          if (Mem_WE) begin
            addr_q    <= MAR;
            wdata_q   <= MDR;
            mmio_q    <= is_mmio(MAR);
            cnt       <= CNT_LOAD;
            dq_en     <= !is_mmio(MAR);
            SRAM_CE_N <= is_mmio(MAR);
            SRAM_WE_N <= is_mmio(MAR);
            SRAM_UB_N <= is_mmio(MAR);
            SRAM_LB_N <= is_mmio(MAR);
            state     <= W_ACC;
          end else if (Mem_OE) begin
            addr_q    <= MAR;
            mmio_q    <= is_mmio(MAR);
            cnt       <= CNT_LOAD;
            SRAM_CE_N <= is_mmio(MAR);
            SRAM_OE_N <= is_mmio(MAR);
            SRAM_UB_N <= is_mmio(MAR);
            SRAM_LB_N <= is_mmio(MAR);
            state     <= R_ACC;
          end
        end
        R_ACC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            Mem_Data  <= mmio_q ? Switches : dq_rd;
            Mem_Ready <= 1'b1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            state     <= HOLD;
          end
        end
        W_ACC: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            SRAM_WE_N <= 1'b1;
            Mem_Ready <= 1'b1;
            state     <= W_REC;
          end
        end
        W_REC: begin
          // Chip stays selected and data stays driven one cycle past WE_N rising.
          if (mmio_q) Hex_Out <= wdata_q;
          dq_en     <= 1'b0;
          SRAM_CE_N <= 1'b1;
          SRAM_UB_N <= 1'b1;
          SRAM_LB_N <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (!Mem_OE && !Mem_WE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (WAIT_CYCLES 1 and 3) share stimulus,
// each with its own async-SRAM model on a pulled-up data bus.
module tb_mem_access_ctrl;
  import lc3_mem_pkg::*;

  localparam logic [15:0] FLOAT = 16'hFFFF;
  localparam int W0 = 1;
  localparam int W1 = 3;

  typedef struct {
    int          ready_cnt;
    int          ready_cyc;
    int          oe_low;
    int          oe_first;
    int          we_low;
    int          we_first;
    int          ce_low;
    int          bl_low;
    int          dq_bad;
    logic [15:0] data;
    logic [15:0] hex;
  } obs_t;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] MAR = '0;
  logic [15:0] MDR = '0;
  logic [15:0] Switches = '0;

  logic [15:0] mem_data [2];
  logic        ready    [2];
  logic [15:0] hex      [2];
  logic [19:0] saddr    [2];
  logic        ce_n [2], oe_n [2], we_n [2], ub_n [2], lb_n [2];
  mem_state_t  st   [2];
  wire  [15:0] dq0, dq1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl #(.WAIT_CYCLES(W0)) dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Switches(Switches),
    .Mem_Data(mem_data[0]), .Mem_Ready(ready[0]), .Hex_Out(hex[0]),
    .SRAM_ADDR(saddr[0]), .SRAM_DQ(dq0),
    .SRAM_CE_N(ce_n[0]), .SRAM_OE_N(oe_n[0]), .SRAM_WE_N(we_n[0]),
    .SRAM_UB_N(ub_n[0]), .SRAM_LB_N(lb_n[0]), .state_dbg(st[0])
  );

  mem_access_ctrl #(.WAIT_CYCLES(W1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
    .MAR(MAR), .MDR(MDR), .Switches(Switches),
    .Mem_Data(mem_data[1]), .Mem_Ready(ready[1]), .Hex_Out(hex[1]),
    .SRAM_ADDR(saddr[1]), .SRAM_DQ(dq1),
    .SRAM_CE_N(ce_n[1]), .SRAM_OE_N(oe_n[1]), .SRAM_WE_N(we_n[1]),
    .SRAM_UB_N(ub_n[1]), .SRAM_LB_N(lb_n[1]), .state_dbg(st[1])
  );

  // Undriven bus reads as all-ones, so high-Z is observable as FLOAT.
  pullup (dq0);
  pullup (dq1);

  // async SRAM models
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic        pre_req = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [15:0] pre_val = '0;

  assign dq0 = (!ce_n[0] && !oe_n[0] && we_n[0]) ? mem0[saddr[0][15:0]] : 16'hzzzz;
  assign dq1 = (!ce_n[1] && !oe_n[1] && we_n[1]) ? mem1[saddr[1][15:0]] : 16'hzzzz;

  always @(negedge Clk) begin
    if (pre_req) begin
      mem0[pre_addr] = pre_val;
      mem1[pre_addr] = pre_val;
    end
    if (!ce_n[0] && !we_n[0]) mem0[saddr[0][15:0]] = dq0;
    if (!ce_n[1] && !we_n[1]) mem1[saddr[1][15:0]] = dq1;
  end

  // scoreboard state
  logic [15:0] exp_mem [logic [15:0]];
  logic [15:0] exp_hex = '0;
  logic [15:0] exp_q [$];
  obs_t        obs [2];

  function automatic int wof(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  // driver tasks
  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    pre_addr = a;
    pre_val  = v;
    pre_req  = 1'b1;
    @(negedge Clk);
    #1 pre_req = 1'b0;
    exp_mem[a] = v;
  endtask

  // Requests are held for cycles 0..hold-1, then the bus is watched for hold+6 cycles.
  task automatic run_access(input logic we, input logic oe, input logic [15:0] a,
                            input logic [15:0] d_in, input int hold);
    logic [15:0] dqv;
    logic [15:0] want;
    logic        mmio;
    int          w;
    mmio = (a == 16'hFFFF);
    for (int d = 0; d < 2; d++) obs[d] = '{default: 0};
    @(negedge Clk);
    MAR = a; MDR = d_in; Mem_WE = we; Mem_OE = oe;
    for (int k = 1; k <= hold + 6; k++) begin
      @(negedge Clk);
      for (int d = 0; d < 2; d++) begin
        w   = wof(d);
        dqv = (d == 0) ? dq0 : dq1;
        if (ready[d]) begin
          obs[d].ready_cnt++;
          if (obs[d].ready_cyc == 0) obs[d].ready_cyc = k;
        end
        if (!oe_n[d]) begin
          obs[d].oe_low++;
          if (obs[d].oe_first == 0) obs[d].oe_first = k;
        end
        if (!we_n[d]) begin
          obs[d].we_low++;
          if (obs[d].we_first == 0) obs[d].we_first = k;
        end
        if (!ce_n[d]) obs[d].ce_low++;
        if (!ub_n[d] || !lb_n[d]) obs[d].bl_low++;
        if (oe_n[d]) begin
          want = (we && !mmio && k <= w + 1) ? d_in : FLOAT;
          if (dqv !== want) obs[d].dq_bad++;
        end
      end
      if (k == 1) begin
        MAR = 16'($urandom);
        MDR = 16'($urandom);
      end
      if (k == hold) begin
        Mem_WE = 1'b0;
        Mem_OE = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) begin
      obs[d].data = mem_data[d];
      obs[d].hex  = hex[d];
    end
  endtask

  // tests
  task automatic test_reset();
    repeat (2) @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (st[d] !== IDLE) begin n_fail++; $display("FAIL rst_state dut%0d got %0d exp %0d", d, st[d], IDLE); end
      n_tests++; if (mem_data[d] !== 16'h0) begin n_fail++; $display("FAIL rst_mem_data dut%0d got %h exp 0000", d, mem_data[d]); end
      n_tests++; if (hex[d] !== 16'h0) begin n_fail++; $display("FAIL rst_hex dut%0d got %h exp 0000", d, hex[d]); end
      n_tests++; if (ready[d] !== 1'b0) begin n_fail++; $display("FAIL rst_ready dut%0d got %b exp 0", d, ready[d]); end
      n_tests++; if (saddr[d] !== 20'h0) begin n_fail++; $display("FAIL rst_addr dut%0d got %h exp 00000", d, saddr[d]); end
      n_tests++;
      if ({ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d]} !== 5'b11111) begin
        n_fail++;
        $display("FAIL rst_strobes dut%0d got %b exp 11111", d, {ce_n[d], oe_n[d], we_n[d], ub_n[d], lb_n[d]});
      end
    end
    n_tests++; if (dq0 !== FLOAT || dq1 !== FLOAT) begin n_fail++; $display("FAIL rst_dq_float got %h/%h exp %h", dq0, dq1, FLOAT); end
    Reset_n = 1'b1;
  endtask

  task automatic test_sram_read();
    preload(16'h3000, 16'hBEEF);
    run_access(1'b0, 1'b1, 16'h3000, 16'h0, 3);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].oe_first !== 1) begin n_fail++; $display("FAIL rd_oe_first dut%0d got %0d exp 1", d, obs[d].oe_first); end
      n_tests++; if (obs[d].oe_low !== wof(d)) begin n_fail++; $display("FAIL rd_oe_len dut%0d got %0d exp %0d", d, obs[d].oe_low, wof(d)); end
      n_tests++; if (obs[d].ready_cyc !== wof(d) + 1) begin n_fail++; $display("FAIL rd_ready_cyc dut%0d got %0d exp %0d", d, obs[d].ready_cyc, wof(d) + 1); end
      n_tests++; if (obs[d].ready_cnt !== 1) begin n_fail++; $display("FAIL rd_ready_cnt dut%0d got %0d exp 1", d, obs[d].ready_cnt); end
      n_tests++; if (obs[d].data !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data dut%0d got %h exp BEEF", d, obs[d].data); end
      n_tests++; if (obs[d].we_low !== 0 || obs[d].dq_bad !== 0) begin n_fail++; $display("FAIL rd_bus dut%0d we_low %0d dq_bad %0d exp 0 0", d, obs[d].we_low, obs[d].dq_bad); end
    end
  endtask

  task automatic test_sram_write();
    run_access(1'b1, 1'b0, 16'h3001, 16'h1234, 3);
    exp_mem[16'h3001] = 16'h1234;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].we_first !== 1) begin n_fail++; $display("FAIL wr_we_first dut%0d got %0d exp 1", d, obs[d].we_first); end
      n_tests++; if (obs[d].we_low !== wof(d)) begin n_fail++; $display("FAIL wr_we_len dut%0d got %0d exp %0d", d, obs[d].we_low, wof(d)); end
      n_tests++; if (obs[d].ce_low !== wof(d) + 1) begin n_fail++; $display("FAIL wr_ce_len dut%0d got %0d exp %0d", d, obs[d].ce_low, wof(d) + 1); end
      n_tests++; if (obs[d].dq_bad !== 0) begin n_fail++; $display("FAIL wr_dq dut%0d bad cycles %0d exp 0", d, obs[d].dq_bad); end
      n_tests++; if (obs[d].ready_cyc !== wof(d) + 1) begin n_fail++; $display("FAIL wr_ready_cyc dut%0d got %0d exp %0d", d, obs[d].ready_cyc, wof(d) + 1); end
    end
    run_access(1'b0, 1'b1, 16'h3001, 16'h0, 3);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].data !== 16'h1234) begin n_fail++; $display("FAIL wr_readback dut%0d got %h exp 1234", d, obs[d].data); end
    end
  endtask

  task automatic test_mmio();
    preload(16'hFFFF, 16'h7777);
    Switches = 16'h00A5;
    run_access(1'b0, 1'b1, 16'hFFFF, 16'h0, 3);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].data !== 16'h00A5) begin n_fail++; $display("FAIL mmio_rd_data dut%0d got %h exp 00A5", d, obs[d].data); end
      n_tests++;
      if (obs[d].ce_low + obs[d].oe_low + obs[d].bl_low !== 0) begin
        n_fail++; $display("FAIL mmio_rd_strobes dut%0d got %0d low cycles exp 0", d, obs[d].ce_low + obs[d].oe_low + obs[d].bl_low);
      end
      n_tests++; if (obs[d].ready_cyc !== wof(d) + 1) begin n_fail++; $display("FAIL mmio_rd_ready dut%0d got %0d exp %0d", d, obs[d].ready_cyc, wof(d) + 1); end
    end
    run_access(1'b1, 1'b0, 16'hFFFF, 16'h0042, 3);
    exp_hex = 16'h0042;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].hex !== exp_hex) begin n_fail++; $display("FAIL mmio_wr_hex dut%0d got %h exp %h", d, obs[d].hex, exp_hex); end
      n_tests++; if (obs[d].ce_low + obs[d].we_low !== 0) begin n_fail++; $display("FAIL mmio_wr_strobes dut%0d got %0d exp 0", d, obs[d].ce_low + obs[d].we_low); end
      n_tests++; if (obs[d].dq_bad !== 0) begin n_fail++; $display("FAIL mmio_wr_dq dut%0d bad cycles %0d exp 0", d, obs[d].dq_bad); end
    end
    n_tests++; if (mem0[16'hFFFF] !== 16'h7777 || mem1[16'hFFFF] !== 16'h7777) begin n_fail++; $display("FAIL mmio_sram_untouched got %h/%h exp 7777", mem0[16'hFFFF], mem1[16'hFFFF]); end
  endtask

  task automatic test_oe_we_both();
    run_access(1'b1, 1'b1, 16'h3002, 16'h5555, 3);
    exp_mem[16'h3002] = 16'h5555;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].oe_low !== 0) begin n_fail++; $display("FAIL both_oe dut%0d got %0d low cycles exp 0", d, obs[d].oe_low); end
      n_tests++; if (obs[d].we_low !== wof(d)) begin n_fail++; $display("FAIL both_we dut%0d got %0d exp %0d", d, obs[d].we_low, wof(d)); end
    end
    run_access(1'b0, 1'b1, 16'h3002, 16'h0, 2);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].data !== 16'h5555) begin n_fail++; $display("FAIL both_readback dut%0d got %h exp 5555", d, obs[d].data); end
    end
  endtask

  task automatic test_long_hold();
    logic [15:0] v;
    v = 16'($urandom_range(0, 16'hFFFE));
    run_access(1'b0, 1'b1, 16'h3000, 16'h0, 10);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].ready_cnt !== 1) begin n_fail++; $display("FAIL long_rd_cnt dut%0d got %0d exp 1", d, obs[d].ready_cnt); end
      n_tests++; if (obs[d].ready_cyc !== wof(d) + 1) begin n_fail++; $display("FAIL long_rd_cyc dut%0d got %0d exp %0d", d, obs[d].ready_cyc, wof(d) + 1); end
    end
    run_access(1'b1, 1'b0, 16'h3003, v, 10);
    exp_mem[16'h3003] = v;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].ready_cnt !== 1) begin n_fail++; $display("FAIL long_wr_cnt dut%0d got %0d exp 1", d, obs[d].ready_cnt); end
      n_tests++; if (obs[d].ready_cyc !== wof(d) + 1) begin n_fail++; $display("FAIL long_wr_cyc dut%0d got %0d exp %0d", d, obs[d].ready_cyc, wof(d) + 1); end
      n_tests++; if (obs[d].we_low !== wof(d)) begin n_fail++; $display("FAIL long_wr_once dut%0d got %0d exp %0d", d, obs[d].we_low, wof(d)); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, v, e;
    logic        mmio, we, oe;
    int          op, hold, w;
    for (int i = 0; i < 8; i++) preload(16'h3000 + 16'(i), 16'($urandom));
    for (int t = 0; t < 40; t++) begin
      op   = $urandom_range(0, 2);
      a    = ($urandom_range(0, 8) == 8) ? 16'hFFFF : 16'h3000 + 16'($urandom_range(0, 7));
      v    = 16'($urandom_range(0, 16'hFFFE));
      hold = $urandom_range(1, 10);
      mmio = (a == 16'hFFFF);
      we   = (op != 0);
      oe   = (op != 1);
      Switches = 16'($urandom);
      if (we) begin
        if (mmio) exp_hex = v;
        else exp_mem[a] = v;
      end else begin
        exp_q.push_back(mmio ? Switches : exp_mem[a]);
      end
      run_access(we, oe, a, v, hold);
      e = 16'h0;
      if (!we) e = exp_q.pop_front();
      for (int d = 0; d < 2; d++) begin
        w = wof(d);
        n_tests++; if (obs[d].ready_cnt !== 1) begin n_fail++; $display("FAIL rnd_ready_cnt t%0d dut%0d got %0d exp 1", t, d, obs[d].ready_cnt); end
        n_tests++; if (obs[d].ready_cyc !== w + 1) begin n_fail++; $display("FAIL rnd_ready_cyc t%0d dut%0d got %0d exp %0d", t, d, obs[d].ready_cyc, w + 1); end
        n_tests++; if (obs[d].dq_bad !== 0) begin n_fail++; $display("FAIL rnd_dq t%0d dut%0d bad cycles %0d exp 0", t, d, obs[d].dq_bad); end
        n_tests++; if (obs[d].ce_low !== (mmio ? 0 : (we ? w + 1 : w))) begin n_fail++; $display("FAIL rnd_ce t%0d dut%0d got %0d exp %0d", t, d, obs[d].ce_low, mmio ? 0 : (we ? w + 1 : w)); end
        if (we) begin
          n_tests++; if (obs[d].hex !== exp_hex) begin n_fail++; $display("FAIL rnd_hex t%0d dut%0d got %h exp %h", t, d, obs[d].hex, exp_hex); end
          n_tests++; if (obs[d].we_low !== (mmio ? 0 : w) || obs[d].oe_low !== 0) begin n_fail++; $display("FAIL rnd_wr_strobes t%0d dut%0d we %0d oe %0d exp %0d 0", t, d, obs[d].we_low, obs[d].oe_low, mmio ? 0 : w); end
        end else begin
          n_tests++; if (obs[d].data !== e) begin n_fail++; $display("FAIL rnd_rd_data t%0d dut%0d got %h exp %h", t, d, obs[d].data, e); end
          n_tests++; if (obs[d].oe_low !== (mmio ? 0 : w) || obs[d].we_low !== 0) begin n_fail++; $display("FAIL rnd_rd_strobes t%0d dut%0d oe %0d we %0d exp %0d 0", t, d, obs[d].oe_low, obs[d].we_low, mmio ? 0 : w); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    run_access(1'b1, 1'b0, 16'hFFFF, 16'h0042, 2);
    exp_hex = 16'h0042;
    n_tests++; if (hex[1] !== exp_hex) begin n_fail++; $display("FAIL rmid_pre_hex got %h exp %h", hex[1], exp_hex); end
    @(negedge Clk);
    MAR = 16'h3100; MDR = 16'h0F0F; Mem_WE = 1'b1;
    @(negedge Clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (we_n[d] !== 1'b0) begin n_fail++; $display("FAIL rmid_in_wacc dut%0d we_n got %b exp 0", d, we_n[d]); end
    end
    #2 Reset_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (we_n[d] !== 1'b1 || ce_n[d] !== 1'b1) begin n_fail++; $display("FAIL rmid_strobes dut%0d we_n %b ce_n %b exp 1 1", d, we_n[d], ce_n[d]); end
      n_tests++; if (st[d] !== IDLE) begin n_fail++; $display("FAIL rmid_state dut%0d got %0d exp %0d", d, st[d], IDLE); end
      n_tests++; if (hex[d] !== 16'h0) begin n_fail++; $display("FAIL rmid_hex dut%0d got %h exp 0000", d, hex[d]); end
    end
    n_tests++; if (dq0 !== FLOAT || dq1 !== FLOAT) begin n_fail++; $display("FAIL rmid_dq_float got %h/%h exp %h", dq0, dq1, FLOAT); end
    Mem_WE = 1'b0;
    exp_hex = 16'h0;
    @(negedge Clk);
    Reset_n = 1'b1;
    run_access(1'b0, 1'b1, 16'h3000, 16'h0, 3);
    for (int d = 0; d < 2; d++) begin
      n_tests++; if (obs[d].data !== exp_mem[16'h3000]) begin n_fail++; $display("FAIL rmid_recover dut%0d got %h exp %h", d, obs[d].data, exp_mem[16'h3000]); end
    end
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_sram_write();
    test_mmio();
    test_oe_we_both();
    test_long_hold();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
